mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single CPU-side port of the cache/RAM memory subsystem (mem_valid/mem_we/mem_addr/mem_w_data/mem_byte_en -> mem_r_data/mem_ready) between two requesters: data port D (load/store) and instruction-fetch port I (read-only).
- Fixed data-priority arbitration with a starvation guard for I.
- Holds ownership across multi-cycle miss stalls.
- Keeps per-port completion and stall statistics.
- Sits between the pipeline's fetch/LSU stages and the memory subsystem.

Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- STARVE_LIMIT, 4, consecutive I-wait cycles before I is forced ahead of D (>=1)
- CNT_WIDTH, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- d_valid  in  1  D request
- d_we  in  1  D write
- d_addr  in  ADDR_WIDTH  D address
- d_w_data  in  DATA_WIDTH  D write data
- d_byte_en  in  DATA_WIDTH/8  D byte enables
- d_r_data  out  DATA_WIDTH  D read data
- d_ready  out  1  D access completes this cycle
- i_valid  in  1  I request (read)
- i_addr  in  ADDR_WIDTH  I address
- i_r_data  out  DATA_WIDTH  I read data
- i_ready  out  1  I access completes this cycle
- mem_valid, mem_we, mem_addr, mem_w_data, mem_byte_en  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  to memory subsystem
- mem_r_data  in  DATA_WIDTH  from memory subsystem
- mem_ready  in  1  from memory subsystem; combinational, low on the same cycle as a miss
- owner_i  out  1  current owner: 1 = I, 0 = D
- stat_clear  in  1  synchronous clear of statistics
- stat_d_done  out  CNT_WIDTH  completed D accesses
- stat_i_done  out  CNT_WIDTH  completed I accesses
- stat_stall  out  CNT_WIDTH  cycles with mem_valid && !mem_ready

Behaviour:
- Registered state: locked (0), lock_owner (0), i_wait (0), three counters (0). All are cleared asynchronously when rst_n = 0.
- Owner selection (combinational):
  - If locked, owner = lock_owner.
  - Else if d_valid && i_valid, owner = I when i_wait == STARVE_LIMIT, otherwise D.
  - Else if i_valid, owner = I.
  - Else owner = D.
- mem_* follow the owner's signals. For owner I: mem_we = 0 and mem_byte_en = all ones.
- mem_valid = the owner's valid. With no requests, mem_valid = 0.
- Requester response:
  - owner's ready = mem_ready && owner's valid; the non-owner's ready = 0.
  - owner's r_data = mem_r_data; the non-owner's r_data = 0.
- Completion occurs when mem_valid && mem_ready. Requests are zero-wait on a hit; an arbitration decision is never registered.
- Lock:
  - Set at posedge when mem_valid && !mem_ready, capturing lock_owner = owner.
  - Cleared at any posedge where mem_ready = 1, whether or not mem_valid is high.
  - The non-owner can never take the port mid-fill.
- Requester rule: once valid is raised, hold valid, addr and data stable until ready.
  - If the locked owner drops valid, lock is still held, mem_valid drops to 0, and lock releases when mem_ready returns.
- i_wait:
  - Increments, saturating at STARVE_LIMIT, on each cycle with i_valid && !(owner==I && mem_ready).
  - Clears on I completion or when i_valid = 0.
- Statistics:
  - Each counter increments on its event and wraps modulo 2^CNT_WIDTH.
  - stat_clear forces 0 at the next posedge and wins over a simultaneous increment.
- Reset mid-operation: lock and counters clear immediately. The memory subsystem is reset from the same source (its rst = ~rst_n), so no transaction survives reset.
- Writes complete in one cycle (write-through) and never set lock.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic {OWN_D, OWN_I} owner_t
  - localparam BYTE_EN_W = DATA_WIDTH/8
- Sub-module arb_stat_counter (CNT_WIDTH counter with inc/clear, clear priority) is instantiated three times.

Test Plan:
- D read hit at 0x100, I idle -> mem_valid=1, owner_i=0, d_ready=1 same cycle, d_r_data=mem_r_data, stat_d_done=1.
- D and I both valid, continuous D hits (0x0,0x4,0x8,...), STARVE_LIMIT=4 -> D wins 4 cycles, 5th cycle owner_i=1, i_ready=1, i_wait returns to 0.
- I read miss (mem_ready low 5 cycles) with d_valid raised on cycle 2 -> owner_i stays 1 all 5 cycles, d_ready=0, stat_stall=5, I completes, D completes next cycle.
- D write 0xDEADBEEF, byte_en=4'b0011, at 0x200 while i_valid=0 -> mem_we=1, mem_byte_en=0011, d_ready=1 same cycle, lock stays 0.
- rst_n pulsed low during a locked miss -> locked=0, counters 0, mem_valid follows inputs immediately after release.
- stat_clear asserted on the same cycle as a D completion -> stat_d_done=0 next cycle; counter at 2^CNT_WIDTH-1 (CNT_WIDTH=4, value 15) plus one completion -> 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {OWN_D, OWN_I} owner_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned BYTE_EN_W      = DEF_DATA_WIDTH / 8;

endpackage

// File: rtl/arb_stat_counter.sv
// Wrapping event counter with a synchronous clear that beats a same-cycle increment.
module arb_stat_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory-subsystem port between the data (D) and instruction-fetch (I) requesters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    d_valid,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_w_data,
    input  logic [DATA_WIDTH/8-1:0] d_byte_en,
    output logic [DATA_WIDTH-1:0]   d_r_data,
    output logic                    d_ready,
    input  logic                    i_valid,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_r_data,
    output logic                    i_ready,
    output logic                    mem_valid,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_w_data,
    output logic [DATA_WIDTH/8-1:0] mem_byte_en,
    input  logic [DATA_WIDTH-1:0]   mem_r_data,
    input  logic                    mem_ready,
    output logic                    owner_i,
    input  logic                    stat_clear,
    output logic [CNT_WIDTH-1:0]    stat_d_done,
    output logic [CNT_WIDTH-1:0]    stat_i_done,
    output logic [CNT_WIDTH-1:0]    stat_stall
);

    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    owner_t            owner;
    owner_t            lock_owner;
    logic              locked;
    logic [WAIT_W-1:0] i_wait;
    logic              owner_is_i;

    // Ownership is purely combinational; only a stalled access pins it via the lock.
    always_comb begin
        owner = OWN_D;
        if (locked) begin
            owner = lock_owner;
        end else if (d_valid && i_valid) begin
            owner = (i_wait == WAIT_W'(STARVE_LIMIT)) ? OWN_I : OWN_D;
        end else if (i_valid) begin
            owner = OWN_I;
        end
    end

    assign owner_is_i = (owner == OWN_I);
    assign owner_i    = owner_is_i;

    always_comb begin
        mem_valid   = d_valid;
        mem_we      = d_we;
        mem_addr    = d_addr;
        mem_w_data  = d_w_data;
        mem_byte_en = d_byte_en;
        d_r_data    = mem_r_data;
        i_r_data    = '0;
        if (owner_is_i) begin
            mem_valid   = i_valid;
            mem_we      = 1'b0;
            mem_addr    = i_addr;
            mem_w_data  = '0;
            mem_byte_en = '1;
            d_r_data    = '0;
            i_r_data    = mem_r_data;
        end
    end

    assign d_ready = !owner_is_i && d_valid && mem_ready;
    assign i_ready = owner_is_i && i_valid && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked     <= 1'b0;
            lock_owner <= OWN_D;
        end else if (mem_ready) begin
            locked <= 1'b0;
        end else if (mem_valid) begin
            locked     <= 1'b1;
            lock_owner <= owner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_wait <= '0;
        end else if (!i_valid || i_ready) begin
            i_wait <= '0;
        end else if (i_wait != WAIT_W'(STARVE_LIMIT)) begin
            i_wait <= i_wait + WAIT_W'(1);
        end
    end

    arb_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_d_done (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (d_ready),
        .clear (stat_clear),
        .count (stat_d_done)
    );

    arb_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_i_done (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_ready),
        .clear (stat_clear),
        .count (stat_i_done)
    );

    arb_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mem_valid && !mem_ready),
        .clear (stat_clear),
        .count (stat_stall)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a behavioural model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SL = 4;
    localparam int unsigned CW = 4;
    localparam int          CMOD = 1 << CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 d_valid, d_we, i_valid;
    logic [AW-1:0]        d_addr, i_addr, mem_addr;
    logic [DW-1:0]        d_w_data, d_r_data, i_r_data, mem_w_data, mem_r_data;
    logic [BYTE_EN_W-1:0] d_byte_en, mem_byte_en;
    logic                 d_ready, i_ready, mem_valid, mem_we, mem_ready, owner_i, stat_clear;
    logic [CW-1:0]        stat_d_done, stat_i_done, stat_stall;

    mem_port_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(SL),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_w_data(d_w_data),
        .d_byte_en(d_byte_en), .d_r_data(d_r_data), .d_ready(d_ready),
        .i_valid(i_valid), .i_addr(i_addr), .i_r_data(i_r_data), .i_ready(i_ready),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_byte_en(mem_byte_en), .mem_r_data(mem_r_data), .mem_ready(mem_ready),
        .owner_i(owner_i), .stat_clear(stat_clear),
        .stat_d_done(stat_d_done), .stat_i_done(stat_i_done), .stat_stall(stat_stall)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: who is mid-fill (-1 none, 0 D, 1 I), how long I has waited, event tallies.
    int fill_owner, starve, m_d, m_i, m_s;
    int e_who;
    logic                 e_valid, e_we, e_dready, e_iready;
    logic [AW-1:0]        e_addr;
    logic [DW-1:0]        e_wdata, e_drd, e_ird;
    logic [BYTE_EN_W-1:0] e_be;

    function automatic void reset_model();
        fill_owner = -1; starve = 0; m_d = 0; m_i = 0; m_s = 0;
    endfunction

    function automatic void predict();
        if (fill_owner >= 0)         e_who = fill_owner;
        else if (d_valid && i_valid) e_who = (starve >= int'(SL)) ? 1 : 0;
        else                         e_who = i_valid ? 1 : 0;
        if (e_who == 1) begin
            e_valid = i_valid; e_we = 1'b0; e_addr = i_addr; e_wdata = '0; e_be = '1;
            e_drd = '0; e_ird = mem_r_data;
        end else begin
            e_valid = d_valid; e_we = d_we; e_addr = d_addr; e_wdata = d_w_data; e_be = d_byte_en;
            e_drd = mem_r_data; e_ird = '0;
        end
        e_dready = (e_who == 0) && e_valid && mem_ready;
        e_iready = (e_who == 1) && e_valid && mem_ready;
    endfunction

    function automatic void commit();
        if (mem_ready)    fill_owner = -1;
        else if (e_valid) fill_owner = e_who;
        if (!i_valid || e_iready) starve = 0;
        else if (starve < int'(SL)) starve++;
        if (stat_clear) begin
            m_d = 0; m_i = 0; m_s = 0;
        end else begin
            m_d = (m_d + int'(e_dready)) % CMOD;
            m_i = (m_i + int'(e_iready)) % CMOD;
            m_s = (m_s + int'(e_valid && !mem_ready)) % CMOD;
        end
    endfunction

    task automatic settle();
        @(negedge clk);
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic clear_stats();
        stat_clear = 1'b1; d_valid = 1'b0; i_valid = 1'b0; d_we = 1'b0; mem_ready = 1'b1;
        settle();
        tick();
        stat_clear = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (stat_d_done !== '0) $display("FAIL reset_d_done got %0d want 0", stat_d_done); else n_pass++;
        n_total++; if (stat_i_done !== '0) $display("FAIL reset_i_done got %0d want 0", stat_i_done); else n_pass++;
        n_total++; if (stat_stall !== '0) $display("FAIL reset_stall got %0d want 0", stat_stall); else n_pass++;
        n_total++; if (owner_i !== 1'b0) $display("FAIL reset_owner got %0b want 0", owner_i); else n_pass++;
        n_total++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got %0b want 0", mem_valid); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_d_read_hit();
        clear_stats();
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_byte_en = '1;
        mem_r_data = 32'hCAFE_0001; mem_ready = 1'b1;
        settle();
        n_total++; if (mem_valid !== 1'b1) $display("FAIL hit_mem_valid got %0b want 1", mem_valid); else n_pass++;
        n_total++; if (owner_i !== 1'b0) $display("FAIL hit_owner got %0b want 0", owner_i); else n_pass++;
        n_total++; if (d_ready !== 1'b1) $display("FAIL hit_d_ready got %0b want 1", d_ready); else n_pass++;
        n_total++; if (d_r_data !== 32'hCAFE_0001) $display("FAIL hit_d_r_data got %h want cafe0001", d_r_data); else n_pass++;
        n_total++; if (mem_addr !== 32'h100) $display("FAIL hit_mem_addr got %h want 00000100", mem_addr); else n_pass++;
        tick();
        d_valid = 1'b0;
        n_total++; if (stat_d_done !== 4'd1) $display("FAIL hit_stat_d_done got %0d want 1", stat_d_done); else n_pass++;
    endtask

    task automatic test_starvation();
        clear_stats();
        d_valid = 1'b1; d_we = 1'b0; i_valid = 1'b1; i_addr = 32'h40; mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic want_i;
            want_i = (k == 4);
            d_addr = 32'(4 * (k < 4 ? k : 4));
            mem_r_data = $urandom;
            settle();
            n_total++; if (owner_i !== want_i) $display("FAIL starve_owner[%0d] got %0b want %0b", k, owner_i, want_i); else n_pass++;
            n_total++; if (i_ready !== want_i) $display("FAIL starve_i_ready[%0d] got %0b want %0b", k, i_ready, want_i); else n_pass++;
            n_total++; if (d_ready !== !want_i) $display("FAIL starve_d_ready[%0d] got %0b want %0b", k, d_ready, !want_i); else n_pass++;
            tick();
        end
        d_valid = 1'b0; i_valid = 1'b0;
    endtask

    task automatic test_i_miss();
        clear_stats();
        i_valid = 1'b1; i_addr = 32'h80; mem_ready = 1'b0; d_addr = 32'h300; d_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d_valid = (k >= 1);
            settle();
            n_total++; if (owner_i !== 1'b1) $display("FAIL miss_owner[%0d] got %0b want 1", k, owner_i); else n_pass++;
            n_total++; if ({d_ready, i_ready} !== 2'b00) $display("FAIL miss_ready[%0d] got %b want 00", k, {d_ready, i_ready}); else n_pass++;
            tick();
        end
        mem_ready = 1'b1; mem_r_data = 32'h1234_5678;
        settle();
        n_total++; if ({owner_i, i_ready, d_ready} !== 3'b110) $display("FAIL miss_fill got %b want 110", {owner_i, i_ready, d_ready}); else n_pass++;
        n_total++; if (i_r_data !== 32'h1234_5678) $display("FAIL miss_i_r_data got %h want 12345678", i_r_data); else n_pass++;
        n_total++; if (d_r_data !== '0) $display("FAIL miss_d_r_data got %h want 0", d_r_data); else n_pass++;
        tick();
        n_total++; if (stat_stall !== 4'd5) $display("FAIL miss_stat_stall got %0d want 5", stat_stall); else n_pass++;
        n_total++; if (stat_i_done !== 4'd1) $display("FAIL miss_stat_i_done got %0d want 1", stat_i_done); else n_pass++;
        i_valid = 1'b0;
        settle();
        n_total++; if ({owner_i, d_ready} !== 2'b01) $display("FAIL miss_d_after got %b want 01", {owner_i, d_ready}); else n_pass++;
        tick();
        d_valid = 1'b0;
        n_total++; if (stat_d_done !== 4'd1) $display("FAIL miss_stat_d_done got %0d want 1", stat_d_done); else n_pass++;
    endtask

    task automatic test_write();
        clear_stats();
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_w_data = 32'hDEAD_BEEF;
        d_byte_en = 4'b0011; mem_ready = 1'b1;
        settle();
        n_total++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we got %0b want 1", mem_we); else n_pass++;
        n_total++; if (mem_byte_en !== 4'b0011) $display("FAIL wr_byte_en got %b want 0011", mem_byte_en); else n_pass++;
        n_total++; if (mem_w_data !== 32'hDEAD_BEEF) $display("FAIL wr_w_data got %h want deadbeef", mem_w_data); else n_pass++;
        n_total++; if (d_ready !== 1'b1) $display("FAIL wr_d_ready got %0b want 1", d_ready); else n_pass++;
        tick();
        d_valid = 1'b0; d_we = 1'b0; i_valid = 1'b1; i_addr = 32'h44;
        settle();
        n_total++; if (owner_i !== 1'b1) $display("FAIL wr_no_lock got %0b want 1", owner_i); else n_pass++;
        n_total++; if ({mem_we, mem_byte_en} !== 5'b0_1111) $display("FAIL wr_i_fields got %b want 01111", {mem_we, mem_byte_en}); else n_pass++;
        n_total++; if (mem_addr !== 32'h44) $display("FAIL wr_i_addr got %h want 00000044", mem_addr); else n_pass++;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_stats();
        i_valid = 1'b1; i_addr = 32'h88; mem_ready = 1'b0;
        settle(); tick();
        settle(); tick();
        d_valid = 1'b1; d_addr = 32'h300; d_we = 1'b0;
        settle();
        n_total++; if (owner_i !== 1'b1) $display("FAIL rstmid_locked got %0b want 1", owner_i); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        reset_model();
        n_total++; if (stat_stall !== '0) $display("FAIL rstmid_stall got %0d want 0", stat_stall); else n_pass++;
        n_total++; if (owner_i !== 1'b0) $display("FAIL rstmid_unlock got %0b want 0", owner_i); else n_pass++;
        i_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        settle();
        n_total++; if ({mem_valid, owner_i, d_ready} !== 3'b101) $display("FAIL rstmid_after got %b want 101", {mem_valid, owner_i, d_ready}); else n_pass++;
        tick();
        d_valid = 1'b0;
        n_total++; if (stat_d_done !== 4'd1) $display("FAIL rstmid_d_done got %0d want 1", stat_d_done); else n_pass++;
    endtask

    task automatic test_stat_clear();
        clear_stats();
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h10; mem_ready = 1'b1; stat_clear = 1'b1;
        settle();
        n_total++; if (d_ready !== 1'b1) $display("FAIL clr_d_ready got %0b want 1", d_ready); else n_pass++;
        tick();
        stat_clear = 1'b0;
        n_total++; if (stat_d_done !== '0) $display("FAIL clr_wins got %0d want 0", stat_d_done); else n_pass++;
        for (int k = 0; k < 15; k++) begin
            settle(); tick();
        end
        n_total++; if (stat_d_done !== 4'd15) $display("FAIL clr_at_max got %0d want 15", stat_d_done); else n_pass++;
        settle(); tick();
        n_total++; if (stat_d_done !== 4'd0) $display("FAIL clr_wrap got %0d want 0", stat_d_done); else n_pass++;
        d_valid = 1'b0;
    endtask

    task automatic test_random();
        logic d_pend, i_pend;
        d_pend = 1'b0; i_pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!d_pend) begin
                d_valid = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1) == 1;
                d_addr = $urandom; d_w_data = $urandom; d_byte_en = BYTE_EN_W'($urandom);
            end
            if (!i_pend) begin
                i_valid = ($urandom_range(0, 2) != 0); i_addr = $urandom;
            end
            stat_clear = ($urandom_range(0, 40) == 0);
            mem_r_data = $urandom;
            mem_ready  = ($urandom_range(0, 3) != 0);
            predict();
            if (e_valid && e_we) mem_ready = 1'b1;
            settle();
            n_total++;
            if ({owner_i, mem_valid, mem_we, d_ready, i_ready} !== {e_who == 1, e_valid, e_we, e_dready, e_iready})
                $display("FAIL rnd_ctrl[%0d] got %b want %b", c, {owner_i, mem_valid, mem_we, d_ready, i_ready},
                         {e_who == 1, e_valid, e_we, e_dready, e_iready});
            else n_pass++;
            n_total++;
            if ({mem_addr, mem_w_data, mem_byte_en, d_r_data, i_r_data} !== {e_addr, e_wdata, e_be, e_drd, e_ird})
                $display("FAIL rnd_data[%0d] got %h want %h", c, {mem_addr, mem_w_data, mem_byte_en, d_r_data, i_r_data},
                         {e_addr, e_wdata, e_be, e_drd, e_ird});
            else n_pass++;
            tick();
            n_total++;
            if ({stat_d_done, stat_i_done, stat_stall} !== {CW'(m_d), CW'(m_i), CW'(m_s)})
                $display("FAIL rnd_stats[%0d] got %h want %h", c, {stat_d_done, stat_i_done, stat_stall},
                         {CW'(m_d), CW'(m_i), CW'(m_s)});
            else n_pass++;
            d_pend = d_valid && !e_dready;
            i_pend = i_valid && !e_iready;
        end
        d_valid = 1'b0; i_valid = 1'b0; stat_clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_w_data = '0; d_byte_en = '0;
        i_valid = 1'b0; i_addr = '0; mem_r_data = '0; mem_ready = 1'b0; stat_clear = 1'b0;
        reset_model();
        test_reset();
        test_d_read_hit();
        test_starvation();
        test_i_miss();
        test_write();
        test_reset_mid();
        test_stat_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
